mem_arbiter: RTL and testbench

- Downstream of the data cache and instruction cache miss ports.
- Arbitrates line-fill and write-back requests from both caches onto a single main-memory port, keeping one transaction outstanding at a time.
- Routes each memory response back to the cache that issued the request, along with that request's thread id.
- Provides a timeout so a hung memory returns a bus error instead of stalling the core.

---
 rtl/mem_arbiter_pkg.sv | 7 +
 rtl/mem_arb_rr_picker.sv | 14 +
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state/source types and default timeout
// for the cache-to-main-memory arbiter.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} mem_arb_state_t;
    typedef enum logic {IC, DC} mem_arb_src_t;
    localparam int MEM_ARB_TIMEOUT = 64;
endpackage

// File: rtl/mem_arb_rr_picker.sv
// mem_arb_rr_picker: two-way combinational round-robin between the I$ and D$;
// on a tie the side that was not granted last wins.
module mem_arb_rr_picker
    import mem_arbiter_pkg::*;
(
    input  logic ic_valid,
    input  logic dc_valid,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_src
);
    assign grant_valid = ic_valid | dc_valid;
    assign grant_src   = (ic_valid && (!dc_valid || last_grant == DC)) ? IC : DC;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises I$/D$ line fills and write-backs onto one memory port,
// one transaction outstanding, with a timeout that turns a hung memory into a bus error.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_WIDTH = 128,
    parameter int ADDR_WIDTH = 20,
    parameter int THR_WIDTH  = 2,
    parameter int TIMEOUT    = MEM_ARB_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ic_req_valid,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    input  logic [THR_WIDTH-1:0]  ic_req_thread_id,
    output logic                  ic_rsp_valid,
    output logic [LINE_WIDTH-1:0] ic_rsp_data,
    output logic [THR_WIDTH-1:0]  ic_rsp_thread_id,
    output logic                  ic_rsp_bus_error,
    input  logic                  dc_req_valid,
    input  logic                  dc_req_is_store,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr,
    input  logic [LINE_WIDTH-1:0] dc_req_data,
    input  logic [THR_WIDTH-1:0]  dc_req_thread_id,
    output logic                  dc_rsp_valid,
    output logic [LINE_WIDTH-1:0] dc_rsp_data,
    output logic [THR_WIDTH-1:0]  dc_rsp_thread_id,
    output logic                  dc_rsp_bus_error,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_is_store,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [LINE_WIDTH-1:0] mem_req_data,
    input  logic                  mem_rsp_valid,
    input  logic [LINE_WIDTH-1:0] mem_rsp_data,
    input  logic                  mem_rsp_error
);
    localparam int TW = $clog2(TIMEOUT + 1);

    mem_arb_state_t        state_q, state_d;
    mem_arb_src_t          src_q, src_d, last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] data_q, data_d, rsp_data_q, rsp_data_d;
    logic                  store_q, store_d, rsp_err_q, rsp_err_d;
    logic [THR_WIDTH-1:0]  thr_q, thr_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  grant_valid, grant_src, ic_fire, dc_fire;

    mem_arb_rr_picker u_picker (
        .ic_valid   (ic_req_valid),
        .dc_valid   (dc_req_valid),
        .last_grant (last_grant_q),
        .grant_valid(grant_valid),
        .grant_src  (grant_src)
    );

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        data_d       = data_q;
        store_d      = store_q;
        thr_d        = thr_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        timer_d      = timer_q;
        case (state_q)
            IDLE: if (grant_valid) begin
                state_d = ISSUE;
                src_d   = mem_arb_src_t'(grant_src);
                addr_d  = grant_src == IC ? ic_req_addr : dc_req_addr;
                data_d  = grant_src == IC ? '0 : dc_req_data;
                store_d = grant_src == DC && dc_req_is_store;
                thr_d   = grant_src == IC ? ic_req_thread_id : dc_req_thread_id;
            end
            ISSUE: if (mem_req_ready) begin
                state_d = WAIT;
                timer_d = '0;
            end
            WAIT: begin
                timer_d = timer_q + TW'(1);
                // A response landing on the timeout cycle still wins.
                if (mem_rsp_valid) begin
                    state_d    = RESP;
                    rsp_data_d = store_q ? '0 : mem_rsp_data;
                    rsp_err_d  = mem_rsp_error;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d    = RESP;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end
            end
            RESP: begin
                state_d      = IDLE;
                last_grant_d = src_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            src_q        <= IC;
            last_grant_q <= DC;
            addr_q       <= '0;
            data_q       <= '0;
            store_q      <= 1'b0;
            thr_q        <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            store_q      <= store_d;
            thr_q        <= thr_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            timer_q      <= timer_d;
        end
    end

    assign mem_req_valid    = state_q == ISSUE;
    assign mem_req_is_store = store_q;
    assign mem_req_addr     = addr_q;
    assign mem_req_data     = data_q;

    assign ic_fire          = state_q == RESP && src_q == IC;
    assign dc_fire          = state_q == RESP && src_q == DC;
    assign ic_rsp_valid     = ic_fire;
    assign ic_rsp_data      = ic_fire ? rsp_data_q : '0;
    assign ic_rsp_thread_id = ic_fire ? thr_q : '0;
    assign ic_rsp_bus_error = ic_fire & rsp_err_q;
    assign dc_rsp_valid     = dc_fire;
    assign dc_rsp_data      = dc_fire ? rsp_data_q : '0;
    assign dc_rsp_thread_id = dc_fire ? thr_q : '0;
    assign dc_rsp_bus_error = dc_fire & rsp_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized rounds checked against
// a transaction-level model of arbitration order, payloads and latency.
module tb_mem_arbiter;
    localparam int LW = 128;
    localparam int AW = 20;
    localparam int TW = 2;
    localparam int TO = 8;

    logic          clock, reset;
    logic          ic_req_valid, ic_rsp_valid, ic_rsp_bus_error;
    logic [AW-1:0] ic_req_addr;
    logic [TW-1:0] ic_req_thread_id, ic_rsp_thread_id;
    logic [LW-1:0] ic_rsp_data;
    logic          dc_req_valid, dc_req_is_store, dc_rsp_valid, dc_rsp_bus_error;
    logic [AW-1:0] dc_req_addr;
    logic [LW-1:0] dc_req_data, dc_rsp_data;
    logic [TW-1:0] dc_req_thread_id, dc_rsp_thread_id;
    logic          mem_req_valid, mem_req_ready, mem_req_is_store;
    logic [AW-1:0] mem_req_addr;
    logic [LW-1:0] mem_req_data, mem_rsp_data;
    logic          mem_rsp_valid, mem_rsp_error;

    int tests = 0;
    int fails = 0;

    int            hs_cyc_q[$];
    logic [AW-1:0] hs_addr_q[$];
    logic [LW-1:0] hs_data_q[$];
    logic          hs_store_q[$];
    int            p_cyc_q[$];
    logic          p_side_q[$];
    logic [LW-1:0] p_data_q[$];
    logic          p_err_q[$];
    logic [TW-1:0] p_thr_q[$];
    int            bad_side;
    logic          stable_ok;

    mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .THR_WIDTH(TW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_thread_id(ic_req_thread_id),
        .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data), .ic_rsp_thread_id(ic_rsp_thread_id),
        .ic_rsp_bus_error(ic_rsp_bus_error),
        .dc_req_valid(dc_req_valid), .dc_req_is_store(dc_req_is_store), .dc_req_addr(dc_req_addr),
        .dc_req_data(dc_req_data), .dc_req_thread_id(dc_req_thread_id),
        .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data), .dc_rsp_thread_id(dc_rsp_thread_id),
        .dc_rsp_bus_error(dc_rsp_bus_error),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_is_store(mem_req_is_store),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_error(mem_rsp_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_inputs();
        ic_req_valid = 0; ic_req_addr = '0; ic_req_thread_id = '0;
        dc_req_valid = 0; dc_req_is_store = 0; dc_req_addr = '0; dc_req_data = '0; dc_req_thread_id = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0; mem_rsp_error = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        repeat (2) @(posedge clock);
        #1 reset = 0;
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Acts as the memory for ncyc cycles: ready after rd stalled ISSUE cycles,
    // response rsp cycles into WAIT (-1 = never), optional stray response late
    // cycles after each pulse. Requesters drop valid the cycle after their pulse.
    task automatic run_txn(input int rd, input int rsp, input logic [LW-1:0] rdata,
                           input logic rerr, input int late, input int ncyc);
        int issue_cnt, rsp_at, late_at;
        logic have_ref, drop_ic, drop_dc;
        logic [AW-1:0] ref_addr;
        logic [LW-1:0] ref_data;
        logic ref_store;
        hs_cyc_q.delete(); hs_addr_q.delete(); hs_data_q.delete(); hs_store_q.delete();
        p_cyc_q.delete(); p_side_q.delete(); p_data_q.delete(); p_err_q.delete(); p_thr_q.delete();
        bad_side = 0; stable_ok = 1; have_ref = 0;
        issue_cnt = 0; rsp_at = -1; late_at = -1;
        ref_addr = '0; ref_data = '0; ref_store = 0;
        mem_req_ready = (rd == 0); mem_rsp_valid = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clock);
            if (mem_req_valid) begin
                if (!have_ref) begin
                    ref_addr = mem_req_addr; ref_data = mem_req_data; ref_store = mem_req_is_store;
                    have_ref = 1;
                end else if (mem_req_addr !== ref_addr || mem_req_data !== ref_data || mem_req_is_store !== ref_store)
                    stable_ok = 0;
            end
            if (mem_req_valid && mem_req_ready) begin
                hs_cyc_q.push_back(c); hs_addr_q.push_back(mem_req_addr);
                hs_data_q.push_back(mem_req_data); hs_store_q.push_back(mem_req_is_store);
                have_ref = 0; issue_cnt = 0;
                rsp_at = rsp >= 0 ? c + 1 + rsp : -1;
            end else if (mem_req_valid) issue_cnt++;
            drop_ic = ic_rsp_valid; drop_dc = dc_rsp_valid;
            if (ic_rsp_valid || dc_rsp_valid) begin
                p_cyc_q.push_back(c); p_side_q.push_back(dc_rsp_valid);
                p_data_q.push_back(dc_rsp_valid ? dc_rsp_data : ic_rsp_data);
                p_err_q.push_back(dc_rsp_valid ? dc_rsp_bus_error : ic_rsp_bus_error);
                p_thr_q.push_back(dc_rsp_valid ? dc_rsp_thread_id : ic_rsp_thread_id);
                if (ic_rsp_valid && (dc_rsp_valid || dc_rsp_data != 0 || dc_rsp_thread_id != 0 || dc_rsp_bus_error))
                    bad_side++;
                if (dc_rsp_valid && (ic_rsp_data != 0 || ic_rsp_thread_id != 0 || ic_rsp_bus_error))
                    bad_side++;
                late_at = late >= 1 ? c + late : -1;
            end
            @(posedge clock);
            #1;
            if (drop_ic) ic_req_valid = 0;
            if (drop_dc) dc_req_valid = 0;
            mem_req_ready = issue_cnt >= rd;
            mem_rsp_valid = (c + 1 == rsp_at) || (c + 1 == late_at);
            mem_rsp_error = (c + 1 == rsp_at) ? rerr : 1'b0;
            mem_rsp_data  = (c + 1 == rsp_at) ? rdata : ~rdata;
        end
        mem_rsp_valid = 0; mem_req_ready = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        clear_inputs();
        #1;
        tests++;
        if ({mem_req_valid, mem_req_is_store, mem_req_addr, mem_req_data} !== '0) begin
            fails++; $display("FAIL reset_mem_req: got %h required 0", {mem_req_valid, mem_req_is_store, mem_req_addr, mem_req_data});
        end
        do_reset();
        @(negedge clock);
        tests++;
        if ({ic_rsp_valid, ic_rsp_data, ic_rsp_thread_id, ic_rsp_bus_error} !== '0) begin
            fails++; $display("FAIL reset_ic_rsp: got %h required 0", {ic_rsp_valid, ic_rsp_data, ic_rsp_thread_id, ic_rsp_bus_error});
        end
        tests++;
        if ({dc_rsp_valid, dc_rsp_data, dc_rsp_thread_id, dc_rsp_bus_error, mem_req_valid} !== '0) begin
            fails++; $display("FAIL reset_dc_rsp: got %h required 0", {dc_rsp_valid, dc_rsp_data, dc_rsp_thread_id, dc_rsp_bus_error, mem_req_valid});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_dc_load();
        dc_req_valid = 1; dc_req_is_store = 0; dc_req_addr = 20'h00040; dc_req_thread_id = 2'd1; dc_req_data = rand_line();
        run_txn(0, 1, {4{32'hDEADBEEF}}, 0, -1, 12);
        tests++;
        if (p_side_q.size() != 1 || p_side_q[0] !== 1'b1) begin
            fails++; $display("FAIL dc_load_pulses: got %0d pulses required 1 on D$", p_side_q.size());
        end else begin
            tests++;
            if (p_data_q[0] !== {4{32'hDEADBEEF}} || p_thr_q[0] !== 2'd1 || p_err_q[0] !== 1'b0) begin
                fails++; $display("FAIL dc_load_rsp: got data %h thr %0d err %0b required deadbeef.. 1 0", p_data_q[0], p_thr_q[0], p_err_q[0]);
            end
            tests++;
            if (p_cyc_q[0] != 4) begin
                fails++; $display("FAIL dc_load_latency: got cycle %0d required 4", p_cyc_q[0]);
            end
        end
        tests++;
        if (hs_addr_q.size() != 1 || hs_addr_q[0] !== 20'h00040 || hs_store_q[0] !== 1'b0) begin
            fails++; $display("FAIL dc_load_mem_req: got %0d handshakes required 1 at addr 00040 load", hs_addr_q.size());
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int round = 0; round < 2; round++) begin
            ic_req_valid = 1; ic_req_addr = 20'h11110; ic_req_thread_id = 2'd2;
            dc_req_valid = 1; dc_req_is_store = 0; dc_req_addr = 20'h22220; dc_req_thread_id = 2'd3;
            run_txn(0, 0, rand_line(), 0, -1, 16);
            tests++;
            if (p_side_q.size() != 2 || p_side_q[0] !== 1'b0 || p_side_q[1] !== 1'b1) begin
                fails++; $display("FAIL rr_order_round%0d: got %0d pulses first %0b required I$ then D$", round, p_side_q.size(), p_side_q.size() > 0 ? p_side_q[0] : 1'bx);
            end else begin
                tests++;
                if (p_thr_q[0] !== 2'd2 || p_thr_q[1] !== 2'd3 || hs_addr_q[0] !== 20'h11110 || hs_addr_q[1] !== 20'h22220) begin
                    fails++; $display("FAIL rr_fields_round%0d: got thr %0d/%0d addr %h/%h required 2/3 11110/22220", round, p_thr_q[0], p_thr_q[1], hs_addr_q[0], hs_addr_q[1]);
                end
            end
        end
    endtask

    task automatic test_store();
        dc_req_valid = 1; dc_req_is_store = 1; dc_req_addr = 20'h0ABC0; dc_req_thread_id = 2'd0; dc_req_data = {16{8'hA5}};
        run_txn(0, 0, {4{32'h12345678}}, 0, -1, 8);
        tests++;
        if (hs_data_q.size() != 1 || hs_data_q[0] !== {16{8'hA5}} || hs_store_q[0] !== 1'b1) begin
            fails++; $display("FAIL store_mem_req: got %0d handshakes data %h required 1 with a5.. store", hs_data_q.size(), hs_data_q.size() > 0 ? hs_data_q[0] : '0);
        end
        tests++;
        if (p_side_q.size() != 1 || p_data_q[0] !== '0 || p_cyc_q[0] != 3) begin
            fails++; $display("FAIL store_rsp: got %0d pulses data %h required 1 pulse zero data at cycle 3", p_side_q.size(), p_data_q.size() > 0 ? p_data_q[0] : '1);
        end
    endtask

    task automatic test_stall();
        ic_req_valid = 1; ic_req_addr = 20'h3C3C0; ic_req_thread_id = 2'd3;
        run_txn(5, 0, {4{32'hCAFEF00D}}, 0, -1, 14);
        tests++;
        if (hs_cyc_q.size() != 1 || hs_cyc_q[0] != 6) begin
            fails++; $display("FAIL stall_handshake: got %0d handshakes first at %0d required 1 at 6", hs_cyc_q.size(), hs_cyc_q.size() > 0 ? hs_cyc_q[0] : -1);
        end
        tests++;
        if (stable_ok !== 1'b1) begin
            fails++; $display("FAIL stall_stable: got %0b required 1", stable_ok);
        end
        tests++;
        if (p_side_q.size() != 1 || p_side_q[0] !== 1'b0 || p_cyc_q[0] != 8 || p_data_q[0] !== {4{32'hCAFEF00D}}) begin
            fails++; $display("FAIL stall_rsp: got %0d pulses required 1 I$ pulse at cycle 8 with cafef00d..", p_side_q.size());
        end
    endtask

    task automatic test_timeout();
        logic [LW-1:0] d;
        d = rand_line() | 1;
        dc_req_valid = 1; dc_req_is_store = 0; dc_req_addr = 20'h00100; dc_req_thread_id = 2'd2;
        run_txn(0, -1, d, 0, 2, 16);
        tests++;
        if (p_side_q.size() != 1 || p_err_q[0] !== 1'b1 || p_data_q[0] !== '0 || p_cyc_q[0] != 10) begin
            fails++; $display("FAIL timeout_rsp: got %0d pulses cycle %0d required 1 error pulse at cycle 10", p_side_q.size(), p_cyc_q.size() > 0 ? p_cyc_q[0] : -1);
        end
        dc_req_valid = 1; dc_req_thread_id = 2'd3;
        run_txn(0, 1, d, 0, -1, 10);
        tests++;
        if (p_side_q.size() != 1 || p_err_q[0] !== 1'b0 || p_data_q[0] !== d || p_thr_q[0] !== 2'd3 || p_cyc_q[0] != 4) begin
            fails++; $display("FAIL timeout_recover: got %0d pulses required 1 clean pulse at cycle 4", p_side_q.size());
        end
        ic_req_valid = 1; ic_req_addr = 20'h00200; ic_req_thread_id = 2'd1;
        run_txn(0, TO - 1, d, 1, -1, 14);
        tests++;
        if (p_side_q.size() != 1 || p_data_q[0] !== d || p_err_q[0] !== 1'b1 || p_cyc_q[0] != 10) begin
            fails++; $display("FAIL timeout_collision: got %0d pulses data %h required memory data at cycle 10", p_side_q.size(), p_data_q.size() > 0 ? p_data_q[0] : '0);
        end
    endtask

    task automatic test_reset_mid();
        dc_req_valid = 1; dc_req_is_store = 0; dc_req_addr = 20'h0F0F0; dc_req_thread_id = 2'd1;
        mem_req_ready = 1;
        repeat (2) @(posedge clock);
        #2 reset = 1;
        #1;
        tests++;
        if ({mem_req_valid, mem_req_is_store, mem_req_addr, mem_req_data, ic_rsp_valid, dc_rsp_valid, dc_rsp_thread_id} !== '0) begin
            fails++; $display("FAIL reset_mid_outputs: got %h required 0", {mem_req_valid, mem_req_addr, dc_rsp_valid, dc_rsp_thread_id});
        end
        dc_req_valid = 0; mem_req_ready = 0;
        @(posedge clock);
        #1 reset = 0;
        run_txn(0, 0, rand_line(), 0, -1, 12);
        tests++;
        if (p_side_q.size() != 0 || hs_cyc_q.size() != 0) begin
            fails++; $display("FAIL reset_mid_no_pulse: got %0d pulses %0d handshakes required 0", p_side_q.size(), hs_cyc_q.size());
        end
        dc_req_valid = 1; dc_req_thread_id = 2'd2;
        run_txn(0, 0, {4{32'h0BADF00D}}, 0, -1, 8);
        tests++;
        if (p_side_q.size() != 1 || p_cyc_q[0] != 3 || p_data_q[0] !== {4{32'h0BADF00D}}) begin
            fails++; $display("FAIL reset_mid_recover: got %0d pulses cycle %0d required 1 at cycle 3", p_side_q.size(), p_cyc_q.size() > 0 ? p_cyc_q[0] : -1);
        end
    endtask

    task automatic test_random();
        logic model_last;
        do_reset();
        model_last = 1;
        for (int r = 0; r < 30; r++) begin
            int pick, rd, rsp, n, t;
            logic [LW-1:0] rdata;
            logic rerr, s;
            logic order[2];
            int exp_cyc[2];
            pick = $urandom_range(0, 2);
            rd = $urandom_range(0, 3);
            rsp = $urandom_range(0, 9) > 7 ? -1 : $urandom_range(0, TO - 1);
            rdata = rand_line(); rerr = $urandom_range(0, 3) == 0;
            ic_req_valid = pick != 1; ic_req_addr = 20'($urandom) & 20'hFFFF0; ic_req_thread_id = 2'($urandom);
            dc_req_valid = pick != 0; dc_req_addr = 20'($urandom) & 20'hFFFF0; dc_req_thread_id = 2'($urandom);
            dc_req_is_store = $urandom_range(0, 1); dc_req_data = rand_line();
            n = pick == 2 ? 2 : 1;
            order[0] = pick == 2 ? !model_last : (pick == 1);
            order[1] = model_last;
            t = 0;
            for (int k = 0; k < n; k++) begin
                exp_cyc[k] = t + 3 + rd + (rsp < 0 ? TO - 1 : rsp);
                t = exp_cyc[k] + 1;
            end
            run_txn(rd, rsp, rdata, rerr, $urandom_range(0, 2), 32);
            tests++;
            if (p_side_q.size() != n || hs_addr_q.size() != n) begin
                fails++; $display("FAIL rand%0d_count: got %0d pulses %0d handshakes required %0d", r, p_side_q.size(), hs_addr_q.size(), n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    s = order[k];
                    tests++;
                    if (p_side_q[k] !== s || p_cyc_q[k] != exp_cyc[k]) begin
                        fails++; $display("FAIL rand%0d_order%0d: got side %0b cycle %0d required %0b %0d", r, k, p_side_q[k], p_cyc_q[k], s, exp_cyc[k]);
                    end
                    tests++;
                    if (p_thr_q[k] !== (s ? dc_req_thread_id : ic_req_thread_id) || p_err_q[k] !== (rsp < 0 ? 1'b1 : rerr) ||
                        p_data_q[k] !== ((rsp < 0 || (s && dc_req_is_store)) ? '0 : rdata)) begin
                        fails++; $display("FAIL rand%0d_rsp%0d: got thr %0d err %0b data %h", r, k, p_thr_q[k], p_err_q[k], p_data_q[k]);
                    end
                    tests++;
                    if (hs_addr_q[k] !== (s ? dc_req_addr : ic_req_addr) || hs_store_q[k] !== (s && dc_req_is_store) ||
                        hs_data_q[k] !== (s ? dc_req_data : '0)) begin
                        fails++; $display("FAIL rand%0d_req%0d: got addr %h store %0b data %h", r, k, hs_addr_q[k], hs_store_q[k], hs_data_q[k]);
                    end
                end
            end
            tests++;
            if (bad_side != 0 || stable_ok !== 1'b1) begin
                fails++; $display("FAIL rand%0d_side: got %0d cross-side pulses stable %0b required 0 and 1", r, bad_side, stable_ok);
            end
            model_last = order[n-1];
        end
    endtask

    initial begin
        test_reset();
        test_dc_load();
        test_round_robin();
        test_store();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
